// File: rtl/game_pkg.sv
// Shared types and constants for the 24-game puzzle selection path.
package game_pkg;

    localparam int NUM_PUZZLES = 16;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] DEFAULT_INDEX = 4'd15;

    // Feedback taps 16,14,13,11 expressed as bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        ISSUE
    } sel_state_e;

    function automatic logic [IDX_W-1:0] fallback_idx(
        input logic [IDX_W-1:0] prev,
        input logic [IDX_W-1:0] skip
    );
        logic [IDX_W-1:0] f;
        f = prev + 1'b1;
        if (f == skip) f = f + 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/puzzle_selector_if.sv
// New-game request in, puzzle index and status out.
interface puzzle_selector_if;
    import game_pkg::*;

    logic             new_game;
    logic [IDX_W-1:0] index;
    logic             index_valid;
    logic             busy;
    logic [7:0]       games_played;

    modport master (
        input  new_game,
        output index,
        output index_valid,
        output busy,
        output games_played
    );

    modport slave (
        output new_game,
        input  index,
        input  index_valid,
        input  busy,
        input  games_played
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is promoted to 1.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= INIT;
        else     lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/puzzle_selector.sv
// Draws the next puzzle ROM index on a new-game edge, rejecting
// repeats and the duplicate slot, with a deterministic fallback.
module puzzle_selector
    import game_pkg::*;
#(
    parameter logic [15:0]      LFSR_SEED  = 16'hACE1,
    parameter int unsigned      MAX_TRIES  = 4,
    parameter logic [IDX_W-1:0] SKIP_INDEX = 4'd14
) (
    input logic               clk,
    input logic               rst,
    puzzle_selector_if.master bus
);

    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic [IDX_W-1:0] cand;
    logic             cand_ok;
    logic             req;

    sel_state_e       state_q, state_d;
    logic [3:0]       tries_q, tries_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       gp_q, gp_d;
    logic             ng_q, ng_d;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:IDX_W];
    assign cand        = lfsr[IDX_W-1:0];
    assign req         = bus.new_game & ~ng_q;
    // The last issued index doubles as the repeat-rejection reference
    assign cand_ok     = (cand != index_q) && (cand != SKIP_INDEX);

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        index_d = index_q;
        gp_d    = gp_q;
        ng_d    = bus.new_game;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                    tries_d = 4'd0;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    index_d = cand;
                    state_d = ISSUE;
                end else if (tries_q == LAST_TRY) begin
                    index_d = fallback_idx(index_q, SKIP_INDEX);
                    state_d = ISSUE;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
        if (valid_d && gp_q != 8'hFF) gp_d = gp_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tries_q <= 4'd0;
            index_q <= DEFAULT_INDEX;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            gp_q    <= 8'd0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            index_q <= index_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            gp_q    <= gp_d;
            ng_q    <= ng_d;
        end
    end

    assign bus.index        = index_q;
    assign bus.index_valid  = valid_q;
    assign bus.busy         = busy_q;
    assign bus.games_played = gp_q;

endmodule

// File: tb/tb_puzzle_selector.sv
// Randomized scoreboard bench for puzzle_selector: two instances,
// the default one and a zero-seed, single-try one that often falls back.
module tb_puzzle_selector;

    typedef struct {
        int idx;
        int cyc;
        int gp;
    } exp_t;

    logic clk;
    logic rst;
    logic new_game;
    int   cyc;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input bit ok, input int d, input string nm,
                       input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d expected %0d", d, nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam logic [15:0] SD = (g == 0) ? 16'hACE1 : 16'h0000;
        localparam int MT = (g == 0) ? 4 : 1;

        puzzle_selector_if bus ();
        assign bus.new_game = new_game;

        puzzle_selector #(
            .LFSR_SEED  (SD),
            .MAX_TRIES  (MT),
            .SKIP_INDEX (4'd14)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Reference model: replays the LFSR sequence and resolves a whole
        // draw at the moment the request edge is accepted.
        logic [15:0] m_lfsr;
        logic        m_ng;
        int          m_prev;
        int          next_idle;
        int          busy_lo;
        int          total;
        int          fallbacks;
        exp_t        q[$];

        always @(posedge clk or posedge rst) begin : model
            logic [15:0] v;
            int          idx;
            int          k;
            bit          hit;
            if (rst) begin
                m_lfsr    <= (SD == 16'h0) ? 16'h0001 : SD;
                m_ng      <= 1'b0;
                m_prev    <= 15;
                next_idle <= 0;
                busy_lo   <= 0;
                total     <= 0;
                q.delete();
            end else begin
                m_lfsr <= step(m_lfsr);
                m_ng   <= new_game;
                if (new_game && !m_ng && cyc >= next_idle) begin
                    v   = step(m_lfsr);
                    hit = 1'b0;
                    idx = 0;
                    k   = MT;
                    for (int i = 0; i < MT && !hit; i++) begin
                        if (int'(v[3:0]) != m_prev && v[3:0] != 4'd14) begin
                            hit = 1'b1;
                            idx = int'(v[3:0]);
                            k   = i + 1;
                        end
                        v = step(v);
                    end
                    if (!hit) begin
                        idx = (m_prev + 1) % 16;
                        if (idx == 14) idx = 15;
                        fallbacks <= fallbacks + 1;
                    end
                    q.push_back('{idx, cyc + k + 1,
                                  (total + 1 > 255) ? 255 : total + 1});
                    m_prev    <= idx;
                    total     <= total + 1;
                    busy_lo   <= cyc + 1;
                    next_idle <= cyc + k + 2;
                end
            end
        end

        initial fallbacks = 0;

        logic m_pv;
        int   m_last;
        int   seen;
        initial seen = 0;

        always @(negedge clk) begin : monitor
            exp_t e;
            if (rst) begin
                m_pv   <= 1'b0;
                m_last <= 15;
            end else begin
                chk(bus.busy == (cyc >= busy_lo && cyc < next_idle), g,
                    "busy", int'(bus.busy),
                    int'(cyc >= busy_lo && cyc < next_idle));
                if (bus.index_valid) begin
                    chk(!m_pv, g, "strobe_twice", 1, 0);
                    if (q.size() == 0) begin
                        chk(1'b0, g, "unexpected_strobe", int'(bus.index), -1);
                    end else begin
                        e = q.pop_front();
                        chk(int'(bus.index) == e.idx, g, "index",
                            int'(bus.index), e.idx);
                        chk(cyc == e.cyc, g, "strobe_cycle", cyc, e.cyc);
                        chk(int'(bus.games_played) == e.gp, g,
                            "games_played", int'(bus.games_played), e.gp);
                    end
                    chk(bus.index != 4'd14, g, "skip_slot", int'(bus.index), 0);
                    chk(int'(bus.index) != m_last, g, "repeat",
                        int'(bus.index), m_last);
                    seen   <= seen | (1 << bus.index);
                    m_last <= int'(bus.index);
                end else if (q.size() != 0 && cyc > q[0].cyc) begin
                    chk(1'b0, g, "missed_strobe", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                m_pv <= bus.index_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hold;
        int low;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        new_game = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk(g_dut[0].bus.index == 4'd15, 0, "rst_index",
            int'(g_dut[0].bus.index), 15);
        chk(!g_dut[0].bus.index_valid, 0, "rst_valid",
            int'(g_dut[0].bus.index_valid), 0);
        chk(!g_dut[0].bus.busy, 0, "rst_busy", int'(g_dut[0].bus.busy), 0);
        chk(g_dut[0].bus.games_played == 8'd0, 0, "rst_gp",
            int'(g_dut[0].bus.games_played), 0);

        // Soak: short pulses, toggles during busy and 50-cycle holds
        n = 0;
        while (g_dut[0].total < 1000 && n < 40000) begin
            hold = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(1, 4);
            low  = $urandom_range(1, 4);
            new_game = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                n++;
            end
            new_game = 1'b0;
            repeat (low) begin
                @(negedge clk);
                n++;
            end
        end
        chk(g_dut[0].total >= 1000, 0, "soak_budget", g_dut[0].total, 1000);
        repeat (8) @(negedge clk);
        chk(g_dut[0].bus.games_played == 8'd255, 0, "gp_saturate",
            int'(g_dut[0].bus.games_played), 255);
        chk(g_dut[1].bus.games_played == 8'd255, 1, "gp_saturate",
            int'(g_dut[1].bus.games_played), 255);
        chk(g_dut[0].seen == 32'hBFFF, 0, "coverage", g_dut[0].seen, 32'hBFFF);
        chk(g_dut[1].seen == 32'hBFFF, 1, "coverage", g_dut[1].seen, 32'hBFFF);
        chk(g_dut[1].fallbacks > 0, 1, "fallback_seen", g_dut[1].fallbacks, 1);
        chk(g_dut[0].q.size() == 0, 0, "pending", g_dut[0].q.size(), 0);
        chk(g_dut[1].q.size() == 0, 1, "pending", g_dut[1].q.size(), 0);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(g_dut[0].bus.index == 4'd15, 0, "arst_index",
            int'(g_dut[0].bus.index), 15);
        chk(!g_dut[0].bus.index_valid, 0, "arst_valid",
            int'(g_dut[0].bus.index_valid), 0);
        chk(!g_dut[0].bus.busy, 0, "arst_busy", int'(g_dut[0].bus.busy), 0);
        chk(g_dut[0].bus.games_played == 8'd0, 0, "arst_gp",
            int'(g_dut[0].bus.games_played), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset during the first draw cycle aborts the draw
        repeat (2) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        chk(g_dut[0].bus.busy, 0, "draw_busy", int'(g_dut[0].bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk(!g_dut[0].bus.busy, 0, "abort_busy", int'(g_dut[0].bus.busy), 0);
        chk(g_dut[1].bus.index == 4'd15, 1, "abort_index",
            int'(g_dut[1].bus.index), 15);
        @(negedge clk);
        new_game = 1'b0;
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk(g_dut[0].bus.games_played == 8'd0, 0, "abort_gp",
            int'(g_dut[0].bus.games_played), 0);

        // Single clean draw after reset
        new_game = 1'b1;
        repeat (7) @(negedge clk);
        new_game = 1'b0;
        repeat (2) @(negedge clk);
        chk(g_dut[0].total == 1, 0, "single_draw", g_dut[0].total, 1);
        chk(g_dut[0].bus.games_played == 8'd1, 0, "single_gp",
            int'(g_dut[0].bus.games_played), 1);
        chk(g_dut[1].bus.games_played == 8'd1, 1, "single_gp",
            int'(g_dut[1].bus.games_played), 1);
        chk(g_dut[0].q.size() == 0, 0, "pending_end", g_dut[0].q.size(), 0);
        chk(g_dut[1].q.size() == 0, 1, "pending_end", g_dut[1].q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
